// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// Turns a dual-bank 1R1W SRAM wrapper (1-cycle read latency) into a
// valid/ready streaming FIFO. Writes pass straight through to the wrapper.
// Reads are issued early into a 2-entry register buffer so the consumer sees
// one word per cycle. A read may not follow an in-flight read that sits in the
// other bank, because the wrapper selects rdata by the live rpointer MSB.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 32,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH+1:0]   level,
    output logic                    sram_wen,
    output logic [ADDR_WIDTH-1:0]   sram_wptr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    output logic                    sram_ren,
    output logic [ADDR_WIDTH-1:0]   sram_rptr,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);

    // Pointers carry an extra phase bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]     r_wr_ptr;
    logic [ADDR_WIDTH:0]     r_rd_ptr;
    logic [ADDR_WIDTH-1:0]   r_sram_rptr;
    logic                    r_inflight;
    logic [DATA_WIDTH-1:0]   r_ob0;
    logic [DATA_WIDTH-1:0]   r_ob1;
    logic [1:0]              r_ob_count;

    logic [ADDR_WIDTH:0]     w_mem_count;
    logic                    w_mem_full;
    logic                    w_mem_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_bank_ok;
    logic [2:0]              w_ob_load;
    logic [DATA_WIDTH-1:0]   w_ob0_nxt;
    logic [DATA_WIDTH-1:0]   w_ob1_nxt;
    logic [1:0]              w_ob_count_nxt;
    logic [ADDR_WIDTH+1:0]   w_level_sum;

    assign w_mem_count = r_wr_ptr - r_rd_ptr;
    assign w_mem_full  = (w_mem_count == LP_DEPTH);
    assign w_mem_empty = (w_mem_count == {(ADDR_WIDTH+1){1'b0}});

    // Handshakes, read-issue decision and wrapper write port.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end else begin
            in_ready  = !w_mem_full;
            out_valid = (r_ob_count != 2'd0);
        end
        w_push     = in_valid & in_ready;
        w_pop      = out_valid & out_ready;
        // Words already owned by the buffer once this cycle's pop is taken.
        w_ob_load  = {1'b0, r_ob_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        // Back-to-back reads must stay in the bank of the read still in flight.
        if (r_inflight) begin
            w_bank_ok = (r_rd_ptr[ADDR_WIDTH-1] == r_sram_rptr[ADDR_WIDTH-1]);
        end else begin
            w_bank_ok = 1'b1;
        end
        w_issue    = !rst & !w_mem_empty & (w_ob_load < 3'd2) & w_bank_ok;
        sram_wen   = w_push;
        sram_wptr  = r_wr_ptr[ADDR_WIDTH-1:0];
        sram_wdata = in_data;
        sram_ren   = w_issue;
        sram_rptr  = r_sram_rptr;
    end

    // Output buffer next state: capture the returning read and/or shift on pop.
    always_comb begin
        w_ob0_nxt      = r_ob0;
        w_ob1_nxt      = r_ob1;
        w_ob_count_nxt = r_ob_count;
        case ({w_pop, r_inflight})
            2'b10: begin
                w_ob0_nxt      = r_ob1;
                w_ob_count_nxt = r_ob_count - 2'd1;
            end
            2'b01: begin
                if (r_ob_count == 2'd0) begin
                    w_ob0_nxt = sram_rdata;
                end else begin
                    w_ob1_nxt = sram_rdata;
                end
                w_ob_count_nxt = r_ob_count + 2'd1;
            end
            2'b11: begin
                if (r_ob_count == 2'd1) begin
                    w_ob0_nxt = sram_rdata;
                end else begin
                    w_ob0_nxt = r_ob1;
                    w_ob1_nxt = sram_rdata;
                end
            end
            default: begin
                w_ob_count_nxt = r_ob_count;
            end
        endcase
    end

    // Head-of-FIFO data and occupancy, forced to zero while in reset.
    always_comb begin
        w_level_sum = {1'b0, w_mem_count}
                    + {{(ADDR_WIDTH+1){1'b0}}, r_inflight}
                    + {{ADDR_WIDTH{1'b0}}, r_ob_count};
        if (rst) begin
            out_data = {DATA_WIDTH{1'b0}};
            level    = {(ADDR_WIDTH+2){1'b0}};
        end else begin
            out_data = r_ob0;
            level    = w_level_sum;
        end
    end

    // Pointer, in-flight tracking and held read address for the wrapper.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= {(ADDR_WIDTH+1){1'b0}};
            r_rd_ptr    <= {(ADDR_WIDTH+1){1'b0}};
            r_sram_rptr <= {ADDR_WIDTH{1'b0}};
            r_inflight  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
                r_sram_rptr <= r_rd_ptr[ADDR_WIDTH-1:0];
            end else begin
                r_rd_ptr    <= r_rd_ptr;
                r_sram_rptr <= r_sram_rptr;
            end
            r_inflight <= w_issue;
        end
    end

    // Output buffer registers; in-flight data is discarded by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ob0      <= {DATA_WIDTH{1'b0}};
            r_ob1      <= {DATA_WIDTH{1'b0}};
            r_ob_count <= 2'd0;
        end else begin
            r_ob0      <= w_ob0_nxt;
            r_ob1      <= w_ob1_nxt;
            r_ob_count <= w_ob_count_nxt;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: a dual-bank SRAM wrapper model, a queue-based
// reference FIFO and directed/random stimulus covering reset, fill, streaming,
// wrap, full boundary and backpressure.
module tb_sram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] level;
    logic       sram_wen;
    logic [4:0] sram_wptr;
    logic [7:0] sram_wdata;
    logic       sram_ren;
    logic [4:0] sram_rptr;
    logic [7:0] sram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  q[$];
    int unsigned wcount;
    int unsigned rcount;
    logic        prev_ren;
    logic [4:0]  prev_raddr;
    logic        prev_hold;
    logic [7:0]  prev_data;
    int          hold_events;

    // Values sampled in the most recent cycle
    logic       s_out_valid;
    logic       s_in_ready;
    logic [7:0] s_out_data;
    logic [6:0] s_level;
    logic       s_pop;

    // Wrapper model: two banks, rdata selected by the live rpointer MSB.
    logic [7:0] bank0 [16];
    logic [7:0] bank1 [16];

    always @(posedge clk) begin
        if (sram_wen) begin
            if (sram_wptr[4]) bank1[sram_wptr[3:0]] <= sram_wdata;
            else              bank0[sram_wptr[3:0]] <= sram_wdata;
        end
    end

    assign sram_rdata = sram_rptr[4] ? bank1[sram_rptr[3:0]] : bank0[sram_rptr[3:0]];

    sram_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .sram_wen   (sram_wen),
        .sram_wptr  (sram_wptr),
        .sram_wdata (sram_wdata),
        .sram_ren   (sram_ren),
        .sram_rptr  (sram_rptr),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One clock cycle: drive, sample at negedge, check, update model.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic r);
        logic acc;
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        s_out_valid = out_valid;
        s_in_ready  = in_ready;
        s_out_data  = out_data;
        s_level     = level;
        acc   = in_valid & in_ready;
        s_pop = out_valid & out_ready;
        if (r) begin
            check_val("rst_in_ready",  32'(in_ready),  32'd0);
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_level",     32'(level),     32'd0);
            check_val("rst_out_data",  32'(out_data),  32'd0);
            check_val("rst_wen",       32'(sram_wen),  32'd0);
            check_val("rst_ren",       32'(sram_ren),  32'd0);
            q.delete();
            wcount = 0; rcount = 0; prev_ren = 1'b0; prev_hold = 1'b0;
        end else begin
            check_val("level", 32'(level), 32'(q.size()));
            check_val("in_ready", 32'(in_ready), 32'((wcount - rcount) < 32'd32));
            check_val("wen", 32'(sram_wen), 32'(acc));
            if (sram_wen) begin
                check_val("wptr",  32'(sram_wptr),  32'(wcount % 32));
                check_val("wdata", 32'(sram_wdata), 32'(in_data));
            end
            if (prev_ren) check_val("rptr_held", 32'(sram_rptr), 32'(prev_raddr));
            if (sram_ren) check_val("ren_nonempty", 32'(wcount != rcount), 32'd1);
            if (prev_hold) begin
                hold_events++;
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_data",  32'(out_data),  32'(prev_data));
            end
            if (s_pop) begin
                check_val("pop_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    check_val("pop_data", 32'(out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (acc) begin
                q.push_back(in_data);
                wcount++;
            end
            prev_ren = sram_ren;
            if (sram_ren) begin
                prev_raddr = rcount[4:0];
                rcount++;
            end
            prev_hold = out_valid & !out_ready;
            prev_data = out_data;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: consumer always ready; mode 1: ready toggles each cycle.
    task automatic drain(input int mode);
        for (int i = 0; i < 400 && q.size() > 0; i++) begin
            cycle(1'b0, 8'h00, (mode == 0) ? 1'b1 : i[0], 1'b0);
        end
        check_val("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic fill34();
        for (int i = 0; i < 34; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            check_val("fill_accept", 32'(s_in_ready), 32'd1);
        end
    endtask

    initial begin
        int pushed, popped, bubbles, drops;
        logic iv;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        hold_events = 0;

        // 1: reset mid-burst, then a single push appears three cycles later
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        cycle(1'b1, 8'h22, 1'b1, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check_val("post_rst_ready", 32'(s_in_ready), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("lat_n1", 32'(s_out_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("lat_n2", 32'(s_out_valid), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("lat_n3_valid", 32'(s_out_valid), 32'd1);
        check_val("lat_n3_data",  32'(s_out_data),  32'hA5);
        drain(0);

        // 2: fill to 34 with consumer stalled, then drain in order
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        fill34();
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        check_val("fill_full_ready", 32'(s_in_ready), 32'd0);
        check_val("fill_level",      32'(s_level),    32'd34);
        drain(0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("fill_level_end", 32'(s_level), 32'd0);

        // 5: full boundary, pop frees a slot one cycle later
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        fill34();
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check_val("full_pop",       32'(s_pop),      32'd1);
        check_val("full_pop_ready", 32'(s_in_ready), 32'd0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0);
        check_val("full_next_ready", 32'(s_in_ready), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("full_level", 32'(s_level), 32'd34);
        drain(0);

        // 3: continuous streaming, one bubble per bank crossing (6 in 100 words)
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        pushed = 0; popped = 0; bubbles = 0; drops = 0;
        for (int c = 0; c < 400 && popped < 100; c++) begin
            iv = (pushed < 100);
            cycle(iv, 8'($urandom), 1'b1, 1'b0);
            if (iv && !s_in_ready) drops++;
            if (iv && s_in_ready) pushed++;
            if (!s_out_valid && popped > 0 && popped < 100) bubbles++;
            if (s_pop) popped++;
        end
        check_val("stream_count",   32'(popped),  32'd100);
        check_val("stream_bubbles", 32'(bubbles), 32'd6);
        check_val("stream_drops",   32'(drops),   32'd0);

        // 4: 70 words with random valid/ready, pointers wrap twice
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        pushed = 0; popped = 0;
        for (int c = 0; c < 3000 && popped < 70; c++) begin
            iv = (pushed < 70) && ($urandom_range(0, 1) == 1);
            cycle(iv, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (iv && s_in_ready) pushed++;
            if (s_pop) popped++;
        end
        check_val("wrap_count", 32'(popped),   32'd70);
        check_val("wrap_empty", 32'(q.size()), 32'd0);

        // 6: out_ready toggling every cycle, held data must stay stable
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(i < 20, 8'($urandom), i[0], 1'b0);
        drain(1);
        check_val("bp_hold_seen", 32'(hold_events > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
